pipe5_fence_sequencer: RTL and testbench

- Sequences FENCE.I cache maintenance for the 5-stage pipeline.
- Steps: drain outstanding data accesses, flush/write back the D-cache, then invalidate the I-cache.
- Drives the dflushed/iflushed handshake back to the pipe5 hazard logic. The hazard logic keeps flushing while ifence is high and either flag is low.
- Sits between the hazard logic and the cache control ports. It is the only block that issues whole-cache maintenance requests.

---
 rtl/pipe5_fence_pkg.sv | 15 +
 rtl/pipe5_fence_if.sv | 50 +++++
 rtl/pipe5_fence_sequencer.sv | 95 +++++++++
 tb/tb_pipe5_fence_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe5_fence_pkg.sv
// Shared types for the FENCE.I cache maintenance sequencer.
// The state encoding is fixed so that IDLE is the all-zero reset value.
package pipe5_fence_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DRAIN  = 3'd1,
      DFLUSH = 3'd2,
      IFLUSH = 3'd3,
      DONE   = 3'd4
   } fence_state_t;

   localparam int FLUSH_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/pipe5_fence_if.sv
// Handshake bundle between hazard logic, the fence sequencer and the cache control ports.
// fence_cycles exists only when PIPE5_FENCE_PERF_EN is defined.
interface pipe5_fence_if #(
   parameter int PERF_W = 32
);

   logic ifence;
   logic d_mem_busy;
   logic dcache_flush;
   logic dcache_flush_done;
   logic icache_clear;
   logic icache_clear_done;
   logic dflushed;
   logic iflushed;
   logic fence_busy;
   logic fence_timeout;

   if (PERF_W < 1) begin : g_bad_perf_w
      $error("pipe5_fence_if: PERF_W must be at least 1");
   end

`ifdef PIPE5_FENCE_PERF_EN
   logic [PERF_W-1:0] fence_cycles;

   modport master (
      input  ifence, d_mem_busy, dcache_flush_done, icache_clear_done,
      output dcache_flush, icache_clear, dflushed, iflushed,
      output fence_busy, fence_timeout, fence_cycles
   );

   modport slave (
      output ifence, d_mem_busy, dcache_flush_done, icache_clear_done,
      input  dcache_flush, icache_clear, dflushed, iflushed,
      input  fence_busy, fence_timeout, fence_cycles
   );
`else
   modport master (
      input  ifence, d_mem_busy, dcache_flush_done, icache_clear_done,
      output dcache_flush, icache_clear, dflushed, iflushed,
      output fence_busy, fence_timeout
   );

   modport slave (
      output ifence, d_mem_busy, dcache_flush_done, icache_clear_done,
      input  dcache_flush, icache_clear, dflushed, iflushed,
      input  fence_busy, fence_timeout
   );
`endif

endinterface

// File: rtl/pipe5_fence_sequencer.sv
// FENCE.I sequencer: drain data accesses, flush the D-cache, then invalidate the I-cache.
// Optional busy-cycle counter is enabled with PIPE5_FENCE_PERF_EN.
module pipe5_fence_sequencer
   import pipe5_fence_pkg::*;
#(
   parameter int FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEFAULT,
   parameter int PERF_W        = 32
) (
   input logic           CLK,
   input logic           RST,
   pipe5_fence_if.master bus
);

   localparam int WD_W = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'((FLUSH_TIMEOUT > 0) ? FLUSH_TIMEOUT - 1 : 0);

   if (FLUSH_TIMEOUT < 0) begin : g_bad_timeout
      $error("pipe5_fence_sequencer: FLUSH_TIMEOUT must not be negative");
   end
   if (PERF_W < 1) begin : g_bad_perf_w
      $error("pipe5_fence_sequencer: PERF_W must be at least 1");
   end

   fence_state_t    state;
   fence_state_t    next_state;
   logic [WD_W-1:0] wd_cnt;
   logic            timeout_q;
   logic            in_flush;
   logic            step_done;
   logic            wd_hit;
   logic            step_complete;

   assign in_flush  = (state == DFLUSH) || (state == IFLUSH);
   assign step_done = ((state == DFLUSH) && bus.dcache_flush_done) ||
                      ((state == IFLUSH) && bus.icache_clear_done);
   assign wd_hit    = (FLUSH_TIMEOUT != 0) && in_flush && (wd_cnt == WD_LAST);
   // A watchdog expiry completes the step exactly as a real done pulse would.
   assign step_complete = step_done || wd_hit;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:   if (bus.ifence) next_state = DRAIN;
         DRAIN: begin
            if (!bus.ifence)          next_state = IDLE;
            else if (!bus.d_mem_busy) next_state = DFLUSH;
         end
         DFLUSH: if (step_complete) next_state = bus.ifence ? IFLUSH : IDLE;
         IFLUSH: if (step_complete) next_state = bus.ifence ? DONE : IDLE;
         DONE:   if (!bus.ifence) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Watchdog restarts on every state change, so it is zero on entry to each flush state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state <= next_state;
         if (next_state != state) begin
            wd_cnt <= '0;
         end else if (in_flush) begin
            wd_cnt <= wd_cnt + 1'b1;
         end
         if (wd_hit && !step_done) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign bus.dcache_flush  = (state == DFLUSH);
   assign bus.icache_clear  = (state == IFLUSH);
   assign bus.dflushed      = (state == IFLUSH) || (state == DONE);
   assign bus.iflushed      = (state == DONE);
   assign bus.fence_busy    = (state != IDLE);
   assign bus.fence_timeout = timeout_q;

`ifdef PIPE5_FENCE_PERF_EN
   logic [PERF_W-1:0] perf_cnt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         perf_cnt <= '0;
      end else if ((state != IDLE) && (perf_cnt != {PERF_W{1'b1}})) begin
         perf_cnt <= perf_cnt + 1'b1;
      end
   end

   assign bus.fence_cycles = perf_cnt;
`endif

endmodule

// File: tb/tb_pipe5_fence_sequencer.sv
// Directed self-checking bench for pipe5_fence_sequencer (FLUSH_TIMEOUT=8, PERF_W=4).
// The perf scenario runs only when PIPE5_FENCE_PERF_EN is defined.
module tb_pipe5_fence_sequencer;

   logic CLK;
   logic RST;
   int   errors;
   int   checks;

   pipe5_fence_if #(.PERF_W(4)) bus ();

   pipe5_fence_sequencer #(
      .FLUSH_TIMEOUT(8),
      .PERF_W       (4)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      bus.ifence            = 1'b0;
      bus.d_mem_busy        = 1'b0;
      bus.dcache_flush_done = 1'b0;
      bus.icache_clear_done = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.fence_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.fence_busy); end
      checks++; if (bus.dcache_flush !== 1'b0 || bus.icache_clear !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b%b want 00", bus.dcache_flush, bus.icache_clear); end
      checks++; if (bus.dflushed !== 1'b0 || bus.iflushed !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b%b want 00", bus.dflushed, bus.iflushed); end
      checks++; if (bus.fence_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b want 0", bus.fence_timeout); end
   endtask

   task automatic test_nominal();
      bus.ifence = 1'b1;
      step();
      checks++; if (bus.fence_busy !== 1'b1 || bus.dcache_flush !== 1'b0) begin errors++; $display("[TB] FAIL nom_drain: busy/flush got %b%b want 10", bus.fence_busy, bus.dcache_flush); end
      step();
      checks++; if (bus.dcache_flush !== 1'b1 || bus.dflushed !== 1'b0) begin errors++; $display("[TB] FAIL nom_dflush: flush/dflushed got %b%b want 10", bus.dcache_flush, bus.dflushed); end
      bus.dcache_flush_done = 1'b1;
      step();
      bus.dcache_flush_done = 1'b0;
      checks++; if (bus.dflushed !== 1'b1 || bus.iflushed !== 1'b0 || bus.icache_clear !== 1'b1 || bus.dcache_flush !== 1'b0) begin errors++; $display("[TB] FAIL nom_iflush: d/i/clear/flush got %b%b%b%b want 1010", bus.dflushed, bus.iflushed, bus.icache_clear, bus.dcache_flush); end
      bus.icache_clear_done = 1'b1;
      step();
      bus.icache_clear_done = 1'b0;
      checks++; if (bus.dflushed !== 1'b1 || bus.iflushed !== 1'b1 || bus.icache_clear !== 1'b0) begin errors++; $display("[TB] FAIL nom_done: d/i/clear got %b%b%b want 110", bus.dflushed, bus.iflushed, bus.icache_clear); end
      step();
      step();
      checks++; if (bus.iflushed !== 1'b1 || bus.fence_busy !== 1'b1) begin errors++; $display("[TB] FAIL nom_hold: iflushed/busy got %b%b want 11", bus.iflushed, bus.fence_busy); end
      bus.ifence = 1'b0;
      step();
      checks++; if (bus.dflushed !== 1'b0 || bus.iflushed !== 1'b0 || bus.fence_busy !== 1'b0) begin errors++; $display("[TB] FAIL nom_release: d/i/busy got %b%b%b want 000", bus.dflushed, bus.iflushed, bus.fence_busy); end
   endtask

   task automatic test_drain();
      bus.ifence     = 1'b1;
      bus.d_mem_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (bus.dcache_flush !== 1'b0 || bus.fence_busy !== 1'b1) begin errors++; $display("[TB] FAIL drain_wait%0d: flush/busy got %b%b want 01", i, bus.dcache_flush, bus.fence_busy); end
      end
      bus.d_mem_busy = 1'b0;
      step();
      checks++; if (bus.dcache_flush !== 1'b1) begin errors++; $display("[TB] FAIL drain_release: flush got %b want 1", bus.dcache_flush); end
      bus.dcache_flush_done = 1'b1;
      step();
      bus.dcache_flush_done = 1'b0;
      // Fence withdrawn while the I-cache clear is in flight: completes, then back to idle.
      bus.ifence            = 1'b0;
      bus.icache_clear_done = 1'b1;
      step();
      bus.icache_clear_done = 1'b0;
      checks++; if (bus.fence_busy !== 1'b0 || bus.iflushed !== 1'b0 || bus.dflushed !== 1'b0) begin errors++; $display("[TB] FAIL drain_iflush_squash: busy/d/i got %b%b%b want 000", bus.fence_busy, bus.dflushed, bus.iflushed); end
   endtask

   task automatic test_squash();
      bus.ifence     = 1'b1;
      bus.d_mem_busy = 1'b1;
      step();
      bus.ifence = 1'b0;
      step();
      checks++; if (bus.fence_busy !== 1'b0 || bus.dcache_flush !== 1'b0) begin errors++; $display("[TB] FAIL squash_drain: busy/flush got %b%b want 00", bus.fence_busy, bus.dcache_flush); end
      bus.ifence     = 1'b1;
      bus.d_mem_busy = 1'b0;
      step();
      step();
      bus.ifence = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (bus.dcache_flush !== 1'b1) begin errors++; $display("[TB] FAIL squash_dflush_hold%0d: flush got %b want 1", i, bus.dcache_flush); end
      end
      bus.dcache_flush_done = 1'b1;
      step();
      bus.dcache_flush_done = 1'b0;
      checks++; if (bus.fence_busy !== 1'b0 || bus.dcache_flush !== 1'b0 || bus.icache_clear !== 1'b0 || bus.dflushed !== 1'b0) begin errors++; $display("[TB] FAIL squash_dflush_end: busy/flush/clear/d got %b%b%b%b want 0000", bus.fence_busy, bus.dcache_flush, bus.icache_clear, bus.dflushed); end
      step();
      checks++; if (bus.icache_clear !== 1'b0) begin errors++; $display("[TB] FAIL squash_no_clear: clear got %b want 0", bus.icache_clear); end
   endtask

   task automatic test_watchdog();
      bus.ifence = 1'b1;
      step();
      step();
      // Entry cycle is DFLUSH cycle 1; seven more steps reach cycle 8.
      for (int i = 0; i < 7; i++) step();
      checks++; if (bus.dcache_flush !== 1'b1 || bus.dflushed !== 1'b0 || bus.fence_timeout !== 1'b0) begin errors++; $display("[TB] FAIL wd_cycle8: flush/d/timeout got %b%b%b want 100", bus.dcache_flush, bus.dflushed, bus.fence_timeout); end
      step();
      checks++; if (bus.dflushed !== 1'b1 || bus.fence_timeout !== 1'b1 || bus.icache_clear !== 1'b1) begin errors++; $display("[TB] FAIL wd_forced: d/timeout/clear got %b%b%b want 111", bus.dflushed, bus.fence_timeout, bus.icache_clear); end
      bus.icache_clear_done = 1'b1;
      step();
      bus.icache_clear_done = 1'b0;
      bus.ifence = 1'b0;
      step();
      test_nominal();
      checks++; if (bus.fence_timeout !== 1'b1) begin errors++; $display("[TB] FAIL wd_sticky: timeout got %b want 1", bus.fence_timeout); end
      do_reset();
      checks++; if (bus.fence_timeout !== 1'b0) begin errors++; $display("[TB] FAIL wd_reset_clear: timeout got %b want 0", bus.fence_timeout); end
   endtask

   task automatic test_spurious_reset();
      bus.dcache_flush_done = 1'b1;
      bus.icache_clear_done = 1'b1;
      step();
      bus.dcache_flush_done = 1'b0;
      bus.icache_clear_done = 1'b0;
      checks++; if (bus.fence_busy !== 1'b0 || bus.dflushed !== 1'b0 || bus.iflushed !== 1'b0) begin errors++; $display("[TB] FAIL spur_idle: busy/d/i got %b%b%b want 000", bus.fence_busy, bus.dflushed, bus.iflushed); end
      bus.ifence     = 1'b1;
      bus.d_mem_busy = 1'b1;
      step();
      bus.dcache_flush_done = 1'b1;
      bus.icache_clear_done = 1'b1;
      step();
      bus.dcache_flush_done = 1'b0;
      bus.icache_clear_done = 1'b0;
      checks++; if (bus.fence_busy !== 1'b1 || bus.dcache_flush !== 1'b0 || bus.dflushed !== 1'b0) begin errors++; $display("[TB] FAIL spur_drain: busy/flush/d got %b%b%b want 100", bus.fence_busy, bus.dcache_flush, bus.dflushed); end
      bus.d_mem_busy = 1'b0;
      step();
      checks++; if (bus.dcache_flush !== 1'b1 || bus.dflushed !== 1'b0) begin errors++; $display("[TB] FAIL spur_dflush: flush/d got %b%b want 10", bus.dcache_flush, bus.dflushed); end
      bus.dcache_flush_done = 1'b1;
      step();
      bus.dcache_flush_done = 1'b0;
      checks++; if (bus.icache_clear !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre_iflush: clear got %b want 1", bus.icache_clear); end
      RST = 1'b1;
      step();
      checks++; if (bus.icache_clear !== 1'b0 || bus.dflushed !== 1'b0 || bus.iflushed !== 1'b0 || bus.fence_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_iflush: clear/d/i/busy got %b%b%b%b want 0000", bus.icache_clear, bus.dflushed, bus.iflushed, bus.fence_busy); end
      RST = 1'b0;
      bus.ifence = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      bus.ifence = 1'b1;
      step();
      step();
      bus.dcache_flush_done = 1'b1;
      step();
      bus.dcache_flush_done = 1'b0;
      bus.icache_clear_done = 1'b1;
      step();
      bus.icache_clear_done = 1'b0;
      bus.ifence = 1'b0;
      step();
      checks++; if (bus.fence_busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle: busy got %b want 0", bus.fence_busy); end
      bus.ifence = 1'b1;
      step();
      step();
      checks++; if (bus.dcache_flush !== 1'b1 || bus.dflushed !== 1'b0) begin errors++; $display("[TB] FAIL b2b_second: flush/d got %b%b want 10", bus.dcache_flush, bus.dflushed); end
      bus.dcache_flush_done = 1'b1;
      step();
      bus.dcache_flush_done = 1'b0;
      bus.icache_clear_done = 1'b1;
      step();
      bus.icache_clear_done = 1'b0;
      checks++; if (bus.iflushed !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done: iflushed got %b want 1", bus.iflushed); end
      bus.ifence = 1'b0;
      step();
   endtask

`ifdef PIPE5_FENCE_PERF_EN
   task automatic test_perf();
      do_reset();
      checks++; if (bus.fence_cycles !== 4'd0) begin errors++; $display("[TB] FAIL perf_reset: got %0d want 0", bus.fence_cycles); end
      bus.ifence     = 1'b1;
      bus.d_mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) step();
      checks++; if (bus.fence_cycles !== 4'd2) begin errors++; $display("[TB] FAIL perf_count: got %0d want 2", bus.fence_cycles); end
      for (int i = 0; i < 17; i++) step();
      checks++; if (bus.fence_cycles !== 4'd15) begin errors++; $display("[TB] FAIL perf_saturate: got %0d want 15", bus.fence_cycles); end
      step();
      checks++; if (bus.fence_cycles !== 4'd15) begin errors++; $display("[TB] FAIL perf_no_wrap: got %0d want 15", bus.fence_cycles); end
      do_reset();
      checks++; if (bus.fence_cycles !== 4'd0) begin errors++; $display("[TB] FAIL perf_clear: got %0d want 0", bus.fence_cycles); end
   endtask
`endif

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "[TB] time limit reached");
   end

   initial begin
      errors = 0;
      checks = 0;
      RST    = 1'b1;
      idle_inputs();
      test_reset();
      test_nominal();
      test_drain();
      test_squash();
      test_watchdog();
      test_spurious_reset();
      test_back_to_back();
`ifdef PIPE5_FENCE_PERF_EN
      test_perf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
